// File: rtl/ripple_pkg.sv
// Shared constants and the default-width count type for the ripple counter.
package ripple_pkg;

  localparam int RIPPLE_DEFAULT_WIDTH = 2;
  localparam int RIPPLE_MAX_WIDTH     = 32;

  typedef logic [RIPPLE_DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/ripple_counter_if.sv
// Count bus of the ripple counter; the counter drives it, consumers observe it.
interface ripple_counter_if #(
  parameter int WIDTH = ripple_pkg::RIPPLE_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] out;

  modport master (output out);
  modport slave  (input  out);

endinterface

// File: rtl/ripple_stage.sv
// One toggle flop of the counter chain, cleared by a synchronous active-high reset.
module ripple_stage (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q
);

  // Reset wins over the toggle enable.
  always_ff @(posedge clk) begin
    if (rst)
      q <= 1'b0;
    else if (en)
      q <= ~q;
  end

endmodule

// File: rtl/ripple_counter.sv
// Free-running WIDTH-bit down-counter built from a chain of synchronous toggle stages.
// Define RIPPLE_CHECK_EN to compile simulation-only checks on width and count behaviour.
module ripple_counter
  import ripple_pkg::*;
#(
  parameter int WIDTH = RIPPLE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  ripple_counter_if.master bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] en;

  // A stage toggles when every lower stage reads zero, giving a decrement per edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign en[i] = 1'b1;
    end else begin : g_upper
      assign en[i] = ~|q[i-1:0];
    end

    ripple_stage u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en[i]),
      .q   (q[i])
    );
  end

  assign bus.out = q;

`ifdef RIPPLE_CHECK_EN
  localparam logic [WIDTH-1:0] ONE = 1;

  if (WIDTH < 1 || WIDTH > RIPPLE_MAX_WIDTH) begin : g_width_check
    $error("ripple_counter: WIDTH %0d outside 1..%0d", WIDTH, RIPPLE_MAX_WIDTH);
  end

  a_reset_clears : assert property (@(posedge clk) rst |=> (q == '0))
    else $error("ripple_counter: count not cleared after reset");

  a_decrement : assert property (@(posedge clk) !rst |=> (q == $past(q) - ONE))
    else $error("ripple_counter: count did not decrement by one");
`endif

endmodule

// File: tb/tb_ripple_counter.sv
// Scoreboard bench: directed vectors drive 2-bit and 4-bit counters sharing one reset.
module tb_ripple_counter;
  import ripple_pkg::*;

  typedef struct {
    count_t     exp2;
    logic [3:0] exp4;
  } expect_t;

  localparam int NVEC = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  expect_t sbQueue[$];

  // Hand-computed vectors: rst, then the 2-bit and 4-bit counts right after that edge.
  logic       rstVec [NVEC] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,1,1,1,1,0,0,0};
  logic [1:0] exp2Vec[NVEC] = '{0,3,2,1,0,3,2,1,0,3,2,1,0,3,2,1,0,3,2,0,3,0,0,0,0,0,3,2,1};
  logic [3:0] exp4Vec[NVEC] = '{0,15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0,15,14,0,15,0,0,0,0,0,
                                15,14,13};

  ripple_counter_if #(.WIDTH(2)) bus2 ();
  ripple_counter_if #(.WIDTH(4)) bus4 ();

  ripple_counter #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  ripple_counter #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input count_t e2, input logic [3:0] e4);
    expect_t item;
    @(negedge clk);
    rst = r;
    item.exp2 = e2;
    item.exp4 = e4;
    sbQueue.push_back(item);
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [3:0] act,
                             input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, req);
    end
  endtask

  // Every rising edge produces a count; compare it once the edge has settled.
  initial begin : monitor
    int idx = 0;
    expect_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) begin
        item = sbQueue.pop_front();
        checkOutput("count_w2", idx, {2'b00, bus2.out}, {2'b00, item.exp2});
        checkOutput("count_w4", idx, bus4.out, item.exp4);
        idx++;
      end
    end
  end

  initial begin : stimulus
    int budget;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(rstVec[i], exp2Vec[i], exp4Vec[i]);
    end
    budget = 20;
    while (sbQueue.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sbQueue.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d required=0", sbQueue.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
